// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared control-path types for the RV32I 5-stage core (IF, ID, EXE, LS, WB).
//   e_data_hazard     : EXE operand bypass select
//   e_branch_result   : branch/jump resolution of the instruction in EXE
//   e_regfile_wb_sel  : writeback source chosen by the decoder
//   s_hazard_entry    : one shadow-pipeline slot {valid, rd, we, is_load}
//   raw_hit()         : read-after-write match of one operand against one slot
// -----------------------------------------------------------------------------
package control_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      NO_HAZARD = 2'd0,
      FROM_EXE  = 2'd1,
      FROM_LS   = 2'd2,
      FROM_WB   = 2'd3
   } e_data_hazard;

   typedef enum logic [1:0] {
      BRANCH_NONE      = 2'd0,
      BRANCH_NOT_TAKEN = 2'd1,
      BRANCH_TAKEN     = 2'd2
   } e_branch_result;

   typedef enum logic [1:0] {
      WB_ALU      = 2'd0,
      WB_MEM_LOAD = 2'd1,
      WB_PC_PLUS4 = 2'd2,
      WB_CSR      = 2'd3
   } e_regfile_wb_sel;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
      logic                  is_load;
   } s_hazard_entry;

   localparam s_hazard_entry HAZARD_ENTRY_EMPTY = '{
      valid   : 1'b0,
      rd      : {REG_ADDR_W{1'b0}},
      we      : 1'b0,
      is_load : 1'b0
   };

   // x0 is hard-wired to zero, so it never produces a dependency.
   function automatic logic raw_hit(input s_hazard_entry entry,
                                    input logic [REG_ADDR_W-1:0] rs,
                                    input logic rs_used);
      return entry.valid & entry.we & (entry.rd == rs) &
             (rs != {REG_ADDR_W{1'b0}}) & rs_used;
   endfunction

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// -----------------------------------------------------------------------------
// hazard_fwd_sel
// Resolves one source operand against the three shadow entries.
// Ports:
//   rs, rs_used        : operand address and whether the instruction reads it
//   exe_entry/ls_entry/wb_entry : shadow slots, youngest first
//   sel                : youngest matching producer (NO_HAZARD if none)
//   src_is_load        : the selected producer is a load
// -----------------------------------------------------------------------------
module hazard_fwd_sel
   import control_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic                  rs_used,
   input  s_hazard_entry         exe_entry,
   input  s_hazard_entry         ls_entry,
   input  s_hazard_entry         wb_entry,
   output e_data_hazard          sel,
   output logic                  src_is_load
);

   logic hit_exe_s;
   logic hit_ls_s;
   logic hit_wb_s;

   // Youngest-first priority so the most recent value of rs is bypassed.
   always_comb begin
      hit_exe_s = raw_hit(exe_entry, rs, rs_used);
      hit_ls_s  = raw_hit(ls_entry,  rs, rs_used);
      hit_wb_s  = raw_hit(wb_entry,  rs, rs_used);
      if (hit_exe_s) begin
         sel         = FROM_EXE;
         src_is_load = exe_entry.is_load;
      end else if (hit_ls_s) begin
         sel         = FROM_LS;
         src_is_load = ls_entry.is_load;
      end else if (hit_wb_s) begin
         sel         = FROM_WB;
         src_is_load = wb_entry.is_load;
      end else begin
         sel         = NO_HAZARD;
         src_is_load = 1'b0;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard controller for the RV32I 5-stage core. Tracks destination
// registers of in-flight instructions in a 3-deep shadow pipe (EXE, LS, WB)
// and derives bypass selects, load-use stalls, branch flushes and mem-wait
// freezes. All control outputs are combinational; only the shadow pipe and
// the stall counter are registered.
//
// Build option: FORWARDING_EN
//   defined   : bypass selects active, only load-use in EXE stalls.
//   undefined : selects tied to NO_HAZARD, any RAW hit stalls until the
//               producer has left WB (up to 3 cycles).
//
// Ports:
//   clk, rstn                     : clock, async active-low reset
//   id_valid, id_rs1/2, id_rs1/2_used, id_rd, id_rd_we, id_wb_sel : ID fields
//   exe_branch_result             : resolution of the instruction in EXE
//   mem_ready                     : low while LS waits on data memory
//   fwd_rs1_sel, fwd_rs2_sel      : EXE operand bypass selects
//   stall_if_id, bubble_exe, flush_if_id, freeze : pipeline control
//   stall_cnt                     : saturating count of stall/freeze cycles
// -----------------------------------------------------------------------------
module hazard_unit
   import control_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_rd_we,
   input  e_regfile_wb_sel   id_wb_sel,
   input  e_branch_result    exe_branch_result,
   input  logic              mem_ready,
   output e_data_hazard      fwd_rs1_sel,
   output e_data_hazard      fwd_rs2_sel,
   output logic              stall_if_id,
   output logic              bubble_exe,
   output logic              flush_if_id,
   output logic              freeze,
   output logic [XLEN-1:0]   stall_cnt
);

   s_hazard_entry   exe_r;
   s_hazard_entry   ls_r;
   s_hazard_entry   wb_r;
   s_hazard_entry   id_entry_s;
   logic [XLEN-1:0] stall_cnt_r;

   e_data_hazard    rs1_sel_s;
   e_data_hazard    rs2_sel_s;
   logic            rs1_src_load_s;
   logic            rs2_src_load_s;
   logic            load_use_s;
   logic            need_stall_s;
   logic            freeze_s;
   logic            flush_s;
   logic            stall_s;
   logic            bubble_s;
   logic            issue_s;

   hazard_fwd_sel u_fwd_rs1 (
      .rs          (id_rs1),
      .rs_used     (id_rs1_used),
      .exe_entry   (exe_r),
      .ls_entry    (ls_r),
      .wb_entry    (wb_r),
      .sel         (rs1_sel_s),
      .src_is_load (rs1_src_load_s)
   );

   hazard_fwd_sel u_fwd_rs2 (
      .rs          (id_rs2),
      .rs_used     (id_rs2_used),
      .exe_entry   (exe_r),
      .ls_entry    (ls_r),
      .wb_entry    (wb_r),
      .sel         (rs2_sel_s),
      .src_is_load (rs2_src_load_s)
   );

   // Shadow slot describing the instruction currently in ID.
   always_comb begin
      id_entry_s.valid   = 1'b1;
      id_entry_s.rd      = id_rd;
      id_entry_s.we      = id_rd_we;
      id_entry_s.is_load = (id_wb_sel == WB_MEM_LOAD);
   end

   // Control decode: freeze > flush > stall; everything gated by rstn so the
   // outputs sit at their reset values while reset is asserted.
   always_comb begin
      load_use_s = ((rs1_sel_s == FROM_EXE) & rs1_src_load_s) |
                   ((rs2_sel_s == FROM_EXE) & rs2_src_load_s);
      freeze_s   = rstn & ~mem_ready;
      // Branch results are ignored while frozen; EXE is re-evaluated later.
      flush_s    = rstn & ~freeze_s & (exe_branch_result == BRANCH_TAKEN);
`ifdef FORWARDING_EN
      need_stall_s = id_valid & load_use_s;
      fwd_rs1_sel  = rstn ? rs1_sel_s : NO_HAZARD;
      fwd_rs2_sel  = rstn ? rs2_sel_s : NO_HAZARD;
`else
      // No bypass network: any older producer blocks issue; load-use is a
      // subset of this.
      need_stall_s = id_valid & (load_use_s |
                                 (rs1_sel_s != NO_HAZARD) |
                                 (rs2_sel_s != NO_HAZARD));
      fwd_rs1_sel  = NO_HAZARD;
      fwd_rs2_sel  = NO_HAZARD;
`endif
      stall_s     = rstn & ~freeze_s & ~flush_s & need_stall_s;
      bubble_s    = rstn & ~freeze_s & (flush_s | need_stall_s);
      issue_s     = id_valid & ~stall_s & ~flush_s & ~freeze_s;
      stall_if_id = stall_s;
      bubble_exe  = bubble_s;
      flush_if_id = flush_s;
      freeze      = freeze_s;
      stall_cnt   = stall_cnt_r;
   end

   // Shadow pipe advance (held while frozen) and saturating stall counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         exe_r       <= HAZARD_ENTRY_EMPTY;
         ls_r        <= HAZARD_ENTRY_EMPTY;
         wb_r        <= HAZARD_ENTRY_EMPTY;
         stall_cnt_r <= {XLEN{1'b0}};
      end else begin
         if (!freeze_s) begin
            wb_r  <= ls_r;
            ls_r  <= exe_r;
            exe_r <= issue_s ? id_entry_s : HAZARD_ENTRY_EMPTY;
         end
         if ((stall_s | freeze_s) & ~(&stall_cnt_r)) begin
            stall_cnt_r <= stall_cnt_r + {{(XLEN-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

- Pipeline hazard controller for the RV32I 5-stage core (IF, ID, EXE, LS, WB).
- Tracks the destination registers of in-flight instructions in a shadow pipeline. Drives the per-operand forwarding selects consumed by the EXE operand muxes.
- Generates load-use stalls, branch-taken flushes and memory-wait freezes.
- Sits beside the decoder; consumes its register/writeback fields and the branch compare result.

## Interface
Parameters:
- XLEN, 32, width of the stall-cycle counter.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1 / id_rs2  in  REG_AW  source register addresses.
- id_rs1_used / id_rs2_used  in  1  operand actually read by the instruction.
- id_rd  in  REG_AW  destination register.
- id_rd_we  in  1  instruction writes rd.
- id_wb_sel  in  e_regfile_wb_sel  writeback source; WB_MEM_LOAD marks a load.
- exe_branch_result  in  e_branch_result  resolution for the instruction in EXE (includes jumps).
- mem_ready  in  1  data memory accepted/returned LS access; low freezes the pipe.
- fwd_rs1_sel / fwd_rs2_sel  out  e_data_hazard  operand bypass select for the instruction entering EXE.
- stall_if_id  out  1  hold PC and the IF/ID register.
- bubble_exe  out  1  load a NOP into ID/EXE.
- flush_if_id  out  1  invalidate the IF/ID register.
- freeze  out  1  hold all pipeline registers (mem wait).
- stall_cnt  out  XLEN  saturating count of cycles with stall_if_id or freeze high.

## Operation
- Shadow pipe: three entries, exe_q, ls_q and wb_q. Each entry is {valid, rd, we, is_load}.
  - Each cycle, unless freeze is high: wb_q<=ls_q, ls_q<=exe_q.
  - exe_q<=ID entry if issued, else an invalid entry.
- Issue condition: id_valid & !stall_if_id & !flush_if_id & !freeze.
- RAW hit for an operand against an entry:
  - requires valid & we & rd==rs & rs!=0 & rs_used;
  - x0 is never forwarded.
- Forward priority, youngest first: EXE hit→FROM_EXE, else LS hit→FROM_LS, else WB hit→FROM_WB, else NO_HAZARD.
- Load-use: an EXE hit with exe_q.is_load raises stall_if_id=1 and bubble_exe=1 for that cycle.
  - On the next cycle the load sits in LS and the select becomes FROM_LS.
  - Net penalty is one cycle.
- Branch taken: exe_branch_result==BRANCH_TAKEN raises flush_if_id=1 and bubble_exe=1.
  - The ID instruction is not issued.
  - Flush overrides stall; stall_if_id=0 that cycle so the PC takes the target.
- Memory wait: mem_ready=0 raises freeze=1.
  - Shadow pipe holds its value.
  - stall_if_id, bubble_exe and flush_if_id are all 0.
  - Selects remain valid for the held state.
- stall_cnt increments by 1 on each cycle with (stall_if_id|freeze) and saturates at all-ones.
- Reset mid-operation: all shadow entries become invalid immediately and stall_cnt clears; the pipe restarts empty.

## Timing
- All outputs are combinational from the shadow registers and the ID/EXE/LS inputs. There is no register on the output path.
- Reset values (asserted while rstn=0, independent of inputs): fwd_*_sel=NO_HAZARD, stall_if_id=0, bubble_exe=0, flush_if_id=0, freeze=0, stall_cnt=0.
- Forwarding decision: zero-cycle latency relative to ID contents.
- Shadow update: one clock.
- Simultaneous events (highest wins):
  - freeze beats flush, and flush beats load-use stall.
  - While freezing, branch results are ignored; the EXE stage is held and re-evaluated after freeze drops.
- An instruction both reading and writing the same register compares only against older entries, never against itself.

## Configuration
- FORWARDING_EN defined: behaviour as above.
- FORWARDING_EN undefined:
  - fwd_rs1_sel and fwd_rs2_sel are tied to NO_HAZARD.
  - Any RAW hit against exe_q, ls_q or wb_q raises stall_if_id=1 and bubble_exe=1 until the producer leaves WB.
  - The register file is not write-through, so the worst case is 3 stall cycles.
  - The load-use rule is subsumed.

## Structure
- Add to control_pkg:
  - typedef struct s_hazard_entry {valid, rd, we, is_load};
  - localparam REG_ADDR_W=5.
  - e_data_hazard and e_branch_result already live there.
- Sub-module hazard_fwd_sel: operand address plus the three entries → e_data_hazard select and load-hit flag. Instantiated twice, once for rs1 and once for rs2.

## Test plan
- ADD x5 issued, then ADD x6,x5,x1 next cycle → fwd_rs1_sel=FROM_EXE, fwd_rs2_sel=NO_HAZARD, no stall.
- LW x7, then ADD x8,x7,x7:
  - 1st cycle stall_if_id=1, bubble_exe=1;
  - 2nd cycle both selects FROM_LS, stall=0;
  - stall_cnt=1.
- Producer x9 three instructions ahead → FROM_WB. Same test with rd=x0 writer and rs=x0 → NO_HAZARD.
- Load-use stall coinciding with BRANCH_TAKEN in EXE → flush_if_id=1, bubble_exe=1, stall_if_id=0.
- mem_ready low for 4 cycles with a pending EXE hit:
  - freeze=1 for 4 cycles and selects stable;
  - shadow unchanged;
  - stall_cnt +4.
- FORWARDING_EN undefined, ADD x5 then SUB x6,x5,x2 → 3 stall cycles, selects NO_HAZARD. Assert rstn low mid-stall → all outputs at reset values asynchronously.
